// File: rtl/viterbi_rate_sched.sv
// Frame controller for the puncture/speed-map stage ahead of the Viterbi decoder:
// takes one frame descriptor at a time, gates symbol pairs into the speed map, reports completion.
module viterbi_rate_sched #(
   parameter int unsigned P_LEN_W     = 16,
   parameter int unsigned P_MAX_SPEED = 8,
   parameter int unsigned P_FLUSH     = 1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [7:0]         i_cfg_speed,
   input  logic [P_LEN_W-1:0] i_cfg_len,
   input  logic               i_cfg_valid,
   output logic               o_cfg_ready,
   input  logic               i_abort,
   input  logic [1:0]         i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [1:0]         o_map_data,
   output logic               o_map_valid,
   output logic               o_map_reset,
   output logic [7:0]         o_speed,
   output logic               o_busy,
   output logic               o_frame_done,
   output logic               o_err
);

   localparam int unsigned        FLUSH_W    = (P_FLUSH > 1) ? $clog2(P_FLUSH) : 1;
   localparam logic [7:0]         MAX_SPEED  = 8'(P_MAX_SPEED);
   localparam logic [FLUSH_W-1:0] FLUSH_LOAD = (P_FLUSH > 0) ? FLUSH_W'(P_FLUSH - 1) : '0;
   localparam logic [P_LEN_W-1:0] CNT_ONE    = P_LEN_W'(1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StFlush} state_t;

   state_t               r_state, w_state_nxt;
   logic [P_LEN_W-1:0]   r_cnt, w_cnt_nxt;
   logic [7:0]           r_speed, w_speed_nxt;
   logic [FLUSH_W-1:0]   r_flush_cnt, w_flush_nxt;
   logic [1:0]           r_map_data, w_map_data_nxt;
   logic                 r_map_valid, w_map_valid_nxt;
   logic                 r_map_reset, w_map_reset_nxt;
   logic                 r_frame_done, w_done_nxt;
   logic                 r_err, w_err_nxt;

   logic                 w_beat;
   logic                 w_abort;
   logic                 w_speed_bad;

   assign w_beat      = i_valid && (r_state == StRun);
   assign w_abort     = i_abort && (r_state != StIdle);
   assign w_speed_bad = (i_cfg_speed == 8'd0) || (i_cfg_speed > MAX_SPEED);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_speed_nxt     = r_speed;
      w_flush_nxt     = r_flush_cnt;
      w_map_data_nxt  = w_beat ? i_data : r_map_data;
      w_map_valid_nxt = w_beat;
      w_map_reset_nxt = 1'b0;
      w_done_nxt      = 1'b0;
      w_err_nxt       = 1'b0;

      case (r_state)
         StIdle: begin
            if (i_cfg_valid) begin
               if (w_speed_bad) begin
                  w_err_nxt = 1'b1;
               end else begin
                  // A zero-length frame still counts as accepted, so its speed sticks.
                  w_speed_nxt = i_cfg_speed;
                  if (i_cfg_len == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt       = i_cfg_len;
                     w_state_nxt     = StLoad;
                     w_map_reset_nxt = 1'b1;
                  end
               end
            end
         end
         StLoad: begin
            w_state_nxt = StRun;
         end
         StRun: begin
            if (w_beat) begin
               w_cnt_nxt = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  if (P_FLUSH == 0) begin
                     w_state_nxt = StIdle;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = StFlush;
                     w_flush_nxt = FLUSH_LOAD;
                  end
               end
            end
         end
         StFlush: begin
            if (r_flush_cnt == '0) begin
               w_state_nxt = StIdle;
               w_done_nxt  = 1'b1;
            end else begin
               w_flush_nxt = r_flush_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase

      // Abort overrides any completion decided above; a beat taken this cycle still goes out.
      if (w_abort) begin
         w_state_nxt     = StIdle;
         w_cnt_nxt       = '0;
         w_map_reset_nxt = 1'b1;
         w_done_nxt      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_speed      <= 8'd1;
         r_flush_cnt  <= '0;
         r_map_data   <= 2'b00;
         r_map_valid  <= 1'b0;
         r_map_reset  <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_speed      <= w_speed_nxt;
         r_flush_cnt  <= w_flush_nxt;
         r_map_data   <= w_map_data_nxt;
         r_map_valid  <= w_map_valid_nxt;
         r_map_reset  <= w_map_reset_nxt;
         r_frame_done <= w_done_nxt;
         r_err        <= w_err_nxt;
      end
   end

   assign o_cfg_ready  = (r_state == StIdle);
   assign o_ready      = (r_state == StRun);
   assign o_busy       = (r_state != StIdle);
   assign o_map_data   = r_map_data;
   assign o_map_valid  = r_map_valid;
   assign o_map_reset  = r_map_reset;
   assign o_speed      = r_speed;
   assign o_frame_done = r_frame_done;
   assign o_err        = r_err;

   a_run_cnt_nonzero : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (r_state == StRun) |-> (r_cnt != '0));
   a_load_resets_map : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (r_state == StLoad) |-> r_map_reset);
   a_done_err_excl : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(r_frame_done && r_err));

endmodule

// File: tb/tb_viterbi_rate_sched.sv
// Self-checking bench for viterbi_rate_sched: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed event timing and data.
module tb_viterbi_rate_sched;

   localparam int unsigned P_LEN_W     = 16;
   localparam int unsigned P_MAX_SPEED = 8;
   localparam int unsigned P_FLUSH     = 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic [7:0]         cfg_speed = '0;
   logic [P_LEN_W-1:0] cfg_len = '0;
   logic               cfg_valid = 1'b0;
   logic               in_abort = 1'b0;
   logic [1:0]         in_data = '0;
   logic               in_valid = 1'b0;
   logic               o_cfg_ready, o_ready, o_map_valid, o_map_reset;
   logic               o_busy, o_frame_done, o_err;
   logic [1:0]         o_map_data;
   logic [7:0]         o_speed;

   viterbi_rate_sched #(
      .P_LEN_W    (P_LEN_W),
      .P_MAX_SPEED(P_MAX_SPEED),
      .P_FLUSH    (P_FLUSH)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_cfg_speed (cfg_speed),
      .i_cfg_len   (cfg_len),
      .i_cfg_valid (cfg_valid),
      .o_cfg_ready (o_cfg_ready),
      .i_abort     (in_abort),
      .i_data      (in_data),
      .i_valid     (in_valid),
      .o_ready     (o_ready),
      .o_map_data  (o_map_data),
      .o_map_valid (o_map_valid),
      .o_map_reset (o_map_reset),
      .o_speed     (o_speed),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done),
      .o_err       (o_err)
   );

   initial forever #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Frame-level reference: a frame is open from descriptor accept until done/abort; the first
   // open cycle re-aligns the map, then beats are owed, then P_FLUSH drain cycles.
   bit         m_open, m_loading;
   int         m_left, m_drain;
   logic [7:0] m_speed;
   logic [1:0] m_data;
   bit         m_valid, m_reset, m_done, m_err;

   task automatic model_reset();
      m_open = 0; m_loading = 0; m_left = 0; m_drain = 0;
      m_speed = 8'd1; m_data = 2'b00;
      m_valid = 0; m_reset = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit beat;
      beat    = m_open && !m_loading && (m_left > 0) && in_valid;
      m_valid = beat;
      m_reset = 0; m_done = 0; m_err = 0;
      if (beat) m_data = in_data;
      if (!m_open) begin
         if (cfg_valid) begin
            if (cfg_speed == 8'd0 || int'(cfg_speed) > int'(P_MAX_SPEED)) begin
               m_err = 1;
            end else begin
               m_speed = cfg_speed;
               if (cfg_len == '0) begin
                  m_done = 1;
               end else begin
                  m_open = 1; m_loading = 1; m_left = int'(cfg_len); m_drain = 0; m_reset = 1;
               end
            end
         end
      end else if (in_abort) begin
         m_open = 0; m_loading = 0; m_left = 0; m_reset = 1;
      end else if (m_loading) begin
         m_loading = 0;
      end else if (m_left > 0) begin
         if (beat) begin
            m_left--;
            if (m_left == 0 && P_FLUSH == 0) begin m_open = 0; m_done = 1; end
         end
      end else begin
         m_drain++;
         if (m_drain >= int'(P_FLUSH)) begin m_open = 0; m_done = 1; end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // Event capture for the directed checks.
   logic [1:0] got[$];
   int n_reset_ev, reset_cyc, n_done_ev, done_cyc, n_err_ev, first_valid_cyc;
   int n_acc, first_acc_cyc, last_acc_cyc, cfg_cyc;
   bit busy_seen;

   task automatic clear_events();
      got.delete();
      n_reset_ev = 0; reset_cyc = -1; n_done_ev = 0; done_cyc = -1; n_err_ev = 0;
      first_valid_cyc = -1; n_acc = 0; first_acc_cyc = -1; last_acc_cyc = -1; busy_seen = 0;
   endtask

   initial begin
      clear_events();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("cfg_ready", 32'(o_cfg_ready), 32'(!m_open));
            check("ready", 32'(o_ready), 32'(m_open && !m_loading && (m_left > 0)));
            check("busy", 32'(o_busy), 32'(m_open));
            check("map_valid", 32'(o_map_valid), 32'(m_valid));
            check("map_data", 32'(o_map_data), 32'(m_data));
            check("map_reset", 32'(o_map_reset), 32'(m_reset));
            check("speed", 32'(o_speed), 32'(m_speed));
            check("frame_done", 32'(o_frame_done), 32'(m_done));
            check("err", 32'(o_err), 32'(m_err));
            if (o_map_valid) begin
               got.push_back(o_map_data);
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (o_map_reset) begin n_reset_ev++; reset_cyc = cyc; end
            if (o_frame_done) begin n_done_ev++; done_cyc = cyc; end
            if (o_err) n_err_ev++;
            if (o_busy) busy_seen = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cfg(input logic [7:0] sp, input logic [P_LEN_W-1:0] len);
      cfg_speed = sp; cfg_len = len; cfg_valid = 1'b1;
      @(negedge clk);
      check("cfg_ready_at_send", 32'(o_cfg_ready), 32'd1);
      cfg_cyc = cyc;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] d, input bit gap);
      bit ok;
      ok = 0;
      in_valid = 1'b1; in_data = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1; n_acc++; last_acc_cyc = cyc;
            if (n_acc == 1) first_acc_cyc = cyc;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!ok) check("beat_timeout", 32'd0, 32'd1);
      if (gap) tick();
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20 && n_done_ev == 0; i++) tick();
      check(name, 32'(n_done_ev), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   logic [1:0] exp1[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
   logic [1:0] exp4[5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("rst_speed", 32'(o_speed), 32'd1);
      check("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
      check("rst_map_valid", 32'(o_map_valid), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Basic frame: speed 2, four back-to-back beats.
      clear_events();
      send_cfg(8'd2, 16'd4);
      for (int i = 0; i < 4; i++) send_beat(exp1[i], 1'b0);
      wait_done("t1_done_seen");
      check("t1_reset_pulses", 32'(n_reset_ev), 32'd1);
      check("t1_reset_cycle", 32'(reset_cyc - cfg_cyc), 32'd1);
      check("t1_reset_before_beat1", 32'(first_acc_cyc - reset_cyc), 32'd1);
      check("t1_back_to_back", 32'(last_acc_cyc - first_acc_cyc), 32'd3);
      check("t1_data_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd1);
      check("t1_beats_out", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++) check("t1_data", 32'(got[i]), 32'(exp1[i]));
      check("t1_done_latency", 32'(done_cyc - last_acc_cyc), 32'd2);
      check("t1_speed", 32'(o_speed), 32'd2);

      // Illegal speeds from reset state.
      do_reset();
      clear_events();
      send_cfg(8'd0, 16'd4);
      tick();
      send_cfg(8'd9, 16'd4);
      tick(); tick();
      check("t2_err_pulses", 32'(n_err_ev), 32'd2);
      check("t2_busy_seen", 32'(busy_seen), 32'd0);
      check("t2_speed", 32'(o_speed), 32'd1);

      // Zero-length frame; abort in idle must be ignored.
      clear_events();
      in_abort = 1'b1;
      send_cfg(8'd3, 16'd0);
      in_abort = 1'b0;
      tick();
      check("t3_done_pulses", 32'(n_done_ev), 32'd1);
      check("t3_done_cycle", 32'(done_cyc - cfg_cyc), 32'd1);
      check("t3_no_map_reset", 32'(n_reset_ev), 32'd0);
      check("t3_busy_seen", 32'(busy_seen), 32'd0);
      check("t3_speed", 32'(o_speed), 32'd3);

      // len=5 with valid toggling.
      clear_events();
      send_cfg(8'd5, 16'd5);
      for (int i = 0; i < 5; i++) send_beat(exp4[i], i < 4);
      @(negedge clk);
      check("t4_ready_after_last", 32'(o_ready), 32'd0);
      tick();
      wait_done("t4_done_seen");
      check("t4_beats_out", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5 && i < got.size(); i++) check("t4_data", 32'(got[i]), 32'(exp4[i]));
      check("t4_speed", 32'(o_speed), 32'd5);

      // Abort with two beats left, during a beat.
      clear_events();
      send_cfg(8'd4, 16'd4);
      send_beat(2'b01, 1'b0);
      send_beat(2'b10, 1'b0);
      in_valid = 1'b1; in_data = 2'b11; in_abort = 1'b1;
      @(negedge clk);
      check("t5_ready_in_abort", 32'(o_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_abort = 1'b0;
      @(negedge clk);
      check("t5_map_valid", 32'(o_map_valid), 32'd1);
      check("t5_map_data", 32'(o_map_data), 32'd3);
      check("t5_map_reset", 32'(o_map_reset), 32'd1);
      check("t5_cfg_ready", 32'(o_cfg_ready), 32'd1);
      check("t5_busy", 32'(o_busy), 32'd0);
      tick();
      repeat (4) tick();
      check("t5_no_done", 32'(n_done_ev), 32'd0);
      check("t5_beats_out", 32'(got.size()), 32'd3);

      // Reset mid-frame, then a fresh len=1 frame.
      clear_events();
      send_cfg(8'd6, 16'd6);
      send_beat(2'b01, 1'b0);
      send_beat(2'b10, 1'b0);
      in_valid = 1'b1; in_data = 2'b11;
      rst_n = 1'b0;
      #1;
      check("t6_map_data", 32'(o_map_data), 32'd0);
      check("t6_map_valid", 32'(o_map_valid), 32'd0);
      check("t6_map_reset", 32'(o_map_reset), 32'd0);
      check("t6_speed", 32'(o_speed), 32'd1);
      check("t6_busy", 32'(o_busy), 32'd0);
      check("t6_ready", 32'(o_ready), 32'd0);
      check("t6_cfg_ready", 32'(o_cfg_ready), 32'd1);
      check("t6_done_err", 32'({o_frame_done, o_err}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      clear_events();
      send_cfg(8'd7, 16'd1);
      send_beat(2'b10, 1'b0);
      wait_done("t6_done_seen");
      check("t6_done_latency", 32'(done_cyc - last_acc_cyc), 32'd2);
      check("t6_beats_out", 32'(got.size()), 32'd1);
      if (got.size() > 0) check("t6_data", 32'(got[0]), 32'd2);
      check("t6_speed_after", 32'(o_speed), 32'd7);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
